// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory access arbiter.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRamRd,
        StFill,
        StRamWr,
        StUpdate,
        StDone
    } state_e;

    // States that wait on a downstream response and are covered by the timeout.
    function automatic logic is_wait(input state_e s);
        return s inside {StLookup, StRamRd, StFill, StRamWr, StUpdate};
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester, cache and RAM signals of the memory access arbiter.
interface mem_access_arbiter_if;
    import mem_ctrl_pkg::*;

    logic              req_0, req_1, we_0, we_1;
    logic [ADDR_W-1:0] addr_0, addr_1;
    logic [DATA_W-1:0] wdata_0, wdata_1;
    logic              gnt_0, gnt_1, done_0, done_1, err;
    logic [DATA_W-1:0] rdata;

    logic              cache_req, cache_we, cache_response, cache_hit;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata, cache_rdata;

    logic              ram_req, ram_we, ram_response;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    // Arbiter side.
    modport slave (
        input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
        output gnt_0, gnt_1, done_0, done_1, err, rdata,
        output cache_req, cache_we, cache_addr, cache_wdata,
        input  cache_response, cache_hit, cache_rdata,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_response, ram_rdata
    );

    // Requesters plus cache/RAM side.
    modport master (
        output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
        input  gnt_0, gnt_1, done_0, done_1, err, rdata,
        input  cache_req, cache_we, cache_addr, cache_wdata,
        output cache_response, cache_hit, cache_rdata,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_response, ram_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter; last_grant only moves when a grant is taken.
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_last_grant;

    // One-hot grant: a lone request wins, a tie goes to the port not served last.
    always_comb begin
        o_gnt = 2'b00;
        unique case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last_grant ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Remember which port was captured; port 1 after reset so port 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance && (|i_req)) begin
            r_last_grant <= o_gnt[1];
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin request arbiter and cache/RAM access sequencer.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    mem_access_arbiter_if.slave io_bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    state_e            r_state, w_state_nxt;
    logic              r_port, w_port_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_err, w_err_nxt;
    logic              r_gnt, w_gnt_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;

    logic [1:0]        w_req, w_arb_gnt;
    logic              w_advance, w_sel, w_timeout;

    assign w_req     = {io_bus.req_1, io_bus.req_0};
    assign w_sel     = w_arb_gnt[1];
    assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1));

    rr_arbiter2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (w_req),
        .i_advance (w_advance),
        .o_gnt     (w_arb_gnt)
    );

    // Next-state: capture a request in IDLE, then step through the downstream accesses.
    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_gnt_nxt   = 1'b0;
        w_advance   = 1'b0;
        w_cnt_nxt   = '0;
        unique case (r_state)
            StIdle: begin
                if (|w_req) begin
                    w_advance   = 1'b1;
                    w_gnt_nxt   = 1'b1;
                    w_port_nxt  = w_sel;
                    w_we_nxt    = w_sel ? io_bus.we_1    : io_bus.we_0;
                    w_addr_nxt  = w_sel ? io_bus.addr_1  : io_bus.addr_0;
                    w_wdata_nxt = w_sel ? io_bus.wdata_1 : io_bus.wdata_0;
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = w_we_nxt ? StRamWr : StLookup;
                end
            end
            StLookup: begin
                if (io_bus.cache_response) begin
                    if (io_bus.cache_hit) begin
                        w_rdata_nxt = io_bus.cache_rdata;
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StRamRd;
                    end
                end
            end
            StRamRd: begin
                if (io_bus.ram_response) begin
                    w_rdata_nxt = io_bus.ram_rdata;
                    w_state_nxt = StFill;
                end
            end
            StFill:   if (io_bus.cache_response) w_state_nxt = StDone;
            StRamWr:  if (io_bus.ram_response)   w_state_nxt = StUpdate;
            StUpdate: if (io_bus.cache_response) w_state_nxt = StDone;
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase

        // Still waiting: count, or abort once the budget is spent. A response wins over expiry.
        if (is_wait(r_state) && (w_state_nxt == r_state)) begin
            if (w_timeout) begin
                w_err_nxt   = 1'b1;
                w_rdata_nxt = '0;
                w_state_nxt = StDone;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // State and transaction registers, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_gnt   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    logic w_done, w_cache_req, w_ram_req;
    assign w_done      = (r_state == StDone);
    assign w_cache_req = r_state inside {StLookup, StFill, StUpdate};
    assign w_ram_req   = r_state inside {StRamRd, StRamWr};

    assign io_bus.gnt_0       = r_gnt & ~r_port;
    assign io_bus.gnt_1       = r_gnt & r_port;
    assign io_bus.done_0      = w_done & ~r_port;
    assign io_bus.done_1      = w_done & r_port;
    assign io_bus.rdata       = w_done ? r_rdata : '0;
    assign io_bus.err         = w_done & r_err;

    assign io_bus.cache_req   = w_cache_req;
    assign io_bus.cache_we    = r_state inside {StFill, StUpdate};
    assign io_bus.cache_addr  = w_cache_req ? r_addr : '0;
    assign io_bus.cache_wdata = (r_state == StFill)   ? r_rdata :
                                (r_state == StUpdate) ? r_wdata : '0;

    assign io_bus.ram_req     = w_ram_req;
    assign io_bus.ram_we      = (r_state == StRamWr);
    assign io_bus.ram_addr    = w_ram_req ? r_addr : '0;
    assign io_bus.ram_wdata   = (r_state == StRamWr) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: vector table, cache/RAM responders, scoreboard on done.
module tb_mem_access_arbiter;

    localparam int unsigned TIMEOUT = 8;
    localparam int          SILENT  = 1000;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        int          c_lat;
        int          r_lat;
        logic [31:0] c_data;
        logic [31:0] r_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_ram;
        logic [31:0] exp_cw;
        logic [31:0] exp_rw;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        logic        ram;
        logic [31:0] cw;
        logic [31:0] rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t cur;
    exp_t sb[$];
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   ram_entry_cyc = 0;

    mem_access_arbiter_if bus ();

    mem_access_arbiter #(
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic vec_t mk(input logic port, we, input logic [31:0] addr, wdata,
                                input logic hit, input int c_lat, r_lat,
                                input logic [31:0] c_data, r_data, exp_rdata,
                                input logic exp_err, exp_ram,
                                input logic [31:0] exp_cw, exp_rw);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.hit = hit;
        v.c_lat = c_lat; v.r_lat = r_lat; v.c_data = c_data; v.r_data = r_data;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_ram = exp_ram;
        v.exp_cw = exp_cw; v.exp_rw = exp_rw;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.port = v.port; e.addr = v.addr; e.rdata = v.exp_rdata; e.err = v.exp_err;
        e.ram = v.exp_ram; e.cw = v.exp_cw; e.rw = v.exp_rw;
        return e;
    endfunction

    // OR of every DUT output; zero means all outputs are quiet.
    function automatic logic [31:0] outs();
        logic [31:0] x;
        x = bus.rdata | bus.cache_addr | bus.cache_wdata | bus.ram_addr | bus.ram_wdata;
        x = x | {23'b0, bus.gnt_0, bus.gnt_1, bus.done_0, bus.done_1, bus.err,
                 bus.cache_req, bus.cache_we, bus.ram_req, bus.ram_we};
        return x;
    endfunction

    // Cache responder: answers c_lat cycles after cache_req rises.
    initial begin : cache_model
        int n;
        n = 0;
        bus.cache_response = 1'b0;
        bus.cache_hit      = 1'b0;
        bus.cache_rdata    = '0;
        forever begin
            @(negedge clk);
            bus.cache_response = 1'b0;
            bus.cache_hit      = 1'b0;
            bus.cache_rdata    = '0;
            if (bus.cache_req) begin
                if (n == cur.c_lat) begin
                    bus.cache_response = 1'b1;
                    bus.cache_hit      = cur.hit;
                    bus.cache_rdata    = cur.c_data;
                end
                n++;
            end else begin
                n = 0;
            end
        end
    end

    // RAM responder: answers r_lat cycles after ram_req rises.
    initial begin : ram_model
        int n;
        n = 0;
        bus.ram_response = 1'b0;
        bus.ram_rdata    = '0;
        forever begin
            @(negedge clk);
            bus.ram_response = 1'b0;
            bus.ram_rdata    = '0;
            if (bus.ram_req) begin
                if (n == cur.r_lat) begin
                    bus.ram_response = 1'b1;
                    bus.ram_rdata    = cur.r_data;
                end
                n++;
            end else begin
                n = 0;
            end
        end
    end

    // Monitor: tracks downstream traffic per transaction, pops and compares on done.
    initial begin : monitor
        logic        seen_ram;
        logic        addr_bad;
        logic [31:0] seen_cw, seen_rw;
        exp_t        e;
        seen_ram = 1'b0; addr_bad = 1'b0; seen_cw = '0; seen_rw = '0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (bus.gnt_0 || bus.gnt_1) begin
                seen_ram = 1'b0; addr_bad = 1'b0; seen_cw = '0; seen_rw = '0;
            end
            if (bus.ram_req && !seen_ram) begin
                seen_ram      = 1'b1;
                ram_entry_cyc = cyc;
            end
            if (bus.cache_req && bus.cache_we) seen_cw = bus.cache_wdata;
            if (bus.ram_req && bus.ram_we) seen_rw = bus.ram_wdata;
            if (sb.size() > 0) begin
                if (bus.cache_req && (bus.cache_addr !== sb[0].addr)) addr_bad = 1'b1;
                if (bus.ram_req && (bus.ram_addr !== sb[0].addr)) addr_bad = 1'b1;
            end
            if (bus.done_0 || bus.done_1) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: done_0=%b done_1=%b with nothing expected",
                             bus.done_0, bus.done_1);
                end else begin
                    e = sb.pop_front();
                    check("done_port", 32'({bus.done_1, bus.done_0}), e.port ? 32'd2 : 32'd1);
                    check("rdata", bus.rdata, e.rdata);
                    check("err", 32'(bus.err), 32'(e.err));
                    check("ram_used", 32'(seen_ram), 32'(e.ram));
                    check("cache_wdata", seen_cw, e.cw);
                    check("ram_wdata", seen_rw, e.rw);
                    check("addr_ok", 32'(addr_bad), 32'd0);
                end
                done_cnt++;
            end
        end
    end

    // Present one request, push its expectation, wait for its grant and drop req.
    task automatic issue(input vec_t v, output int gcyc);
        cur = v;
        sb.push_back(to_exp(v));
        if (v.port) begin
            bus.req_1 = 1'b1; bus.we_1 = v.we; bus.addr_1 = v.addr; bus.wdata_1 = v.wdata;
        end else begin
            bus.req_0 = 1'b1; bus.we_0 = v.we; bus.addr_0 = v.addr; bus.wdata_0 = v.wdata;
        end
        gcyc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((v.port && bus.gnt_1) || (!v.port && bus.gnt_0)) begin
                gcyc = cyc;
                break;
            end
        end
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        if (gcyc < 0) fail_now("gnt_wait");
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 100 && done_cnt < target; k++) @(negedge clk);
        if (done_cnt < target) fail_now("done_wait");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : main
        vec_t tbl[10];
        vec_t v;
        int   g, c0, nd, ng;
        int   gport[4];
        int   gcyc[4];

        tbl[0] = mk(0, 0, 32'h10, 0, 1, 1, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 32'h20, 0, 0, 1, 2, 32'hBAADBAAD, 32'h12345678, 32'h12345678,
                    0, 1, 32'h12345678, 0);
        tbl[2] = mk(0, 1, 32'h30, 32'hA5A5A5A5, 1, 1, 1, 32'hBAADBAAD, 0, 0,
                    0, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[3] = mk(1, 0, 32'h44, 0, 1, 0, 0, 32'h0BADF00D, 0, 32'h0BADF00D, 0, 0, 0, 0);
        tbl[4] = mk(1, 1, 32'h50, 32'h11223344, 0, 2, 0, 0, 0, 0,
                    0, 1, 32'h11223344, 32'h11223344);
        tbl[5] = mk(0, 0, 32'h60, 0, 0, 0, SILENT, 32'h77777777, 32'h66666666, 0, 1, 1, 0, 0);
        tbl[6] = mk(1, 1, 32'h70, 32'h55AA55AA, 1, 0, SILENT, 0, 0, 0, 1, 1, 0, 32'h55AA55AA);
        tbl[7] = mk(0, 0, 32'h80, 0, 1, SILENT, 0, 32'h99999999, 0, 0, 1, 0, 0, 0);
        tbl[8] = mk(1, 0, 32'h90, 0, 0, 0, 7, 0, 32'hCAFEF00D, 32'hCAFEF00D,
                    0, 1, 32'hCAFEF00D, 0);
        tbl[9] = mk(0, 0, 32'hA0, 0, 0, 7, 0, 0, 32'h87654321, 32'h87654321,
                    0, 1, 32'h87654321, 0);

        cur = tbl[0];
        rst = 1'b1;
        bus.req_0 = 1'b0; bus.we_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
        bus.req_1 = 1'b0; bus.we_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), 32'd0);
        nd = 0;

        // Read-hit latency: gnt at N+1, done at N+3.
        c0 = cyc;
        issue(tbl[0], g);
        nd++;
        check("hit_gnt_lat", 32'(g - c0), 32'd1);
        wait_done(nd);
        check("hit_done_lat", 32'(last_done_cyc - c0), 32'd3);

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i], g);
            nd++;
            wait_done(nd);
        end

        // RAM never answers: done exactly TIMEOUT cycles after RAM_RD entry.
        v = mk(0, 0, 32'hB0, 0, 0, 0, SILENT, 0, 0, 0, 1, 1, 0, 0);
        issue(v, g);
        nd++;
        wait_done(nd);
        check("timeout_lat", 32'(last_done_cyc - ram_entry_cyc), 32'(TIMEOUT));

        // Simultaneous continuous reads after reset: grants alternate 0,1,0,1.
        do_reset();
        cur = mk(0, 0, 32'h100, 0, 1, 1, 0, 32'hC0FFEE00, 0, 32'hC0FFEE00, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            v = cur;
            v.port = j[0];
            v.addr = j[0] ? 32'h104 : 32'h100;
            sb.push_back(to_exp(v));
        end
        bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 32'h100;
        bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 32'h104;
        ng = 0;
        for (int k = 0; k < 200 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.gnt_0 || bus.gnt_1) begin
                gport[ng] = bus.gnt_1 ? 1 : 0;
                gcyc[ng]  = cyc;
                ng++;
            end
        end
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        if (ng < 4) fail_now("rr_grants");
        for (int j = 0; j < ng; j++) check("rr_order", 32'(gport[j]), 32'(j % 2));
        if (ng >= 2) check("b2b_gap", 32'(gcyc[1] - gcyc[0]), 32'd4);
        nd += 4;
        wait_done(nd);

        // Reset in the middle of RAM_RD drops the transfer and quiets every output.
        v = mk(1, 0, 32'hC0, 0, 0, 0, SILENT, 0, 0, 0, 0, 1, 0, 0);
        issue(v, g);
        ng = 0;
        for (int k = 0; k < 20 && !bus.ram_req; k++) @(negedge clk);
        if (!bus.ram_req) fail_now("ram_rd_wait");
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("reset_mid_outputs", outs(), 32'd0);
        rst = 1'b0;

        // Both re-presented: port 0 wins the post-reset tie, port 1 follows.
        cur = mk(0, 0, 32'hD0, 0, 1, 1, 0, 32'h0F0F0F0F, 0, 32'h0F0F0F0F, 0, 0, 0, 0);
        sb.push_back(to_exp(cur));
        v = cur;
        v.port = 1'b1;
        v.addr = 32'hD4;
        sb.push_back(to_exp(v));
        bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 32'hD0;
        bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 32'hD4;
        for (int k = 0; k < 100 && ng < 2; k++) begin
            @(negedge clk);
            if (bus.gnt_0 || bus.gnt_1) begin
                gport[ng] = bus.gnt_1 ? 1 : 0;
                ng++;
                if (bus.gnt_0) bus.req_0 = 1'b0;
                if (bus.gnt_1) bus.req_1 = 1'b0;
            end
        end
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        if (ng < 2) fail_now("post_reset_grants");
        else begin
            check("post_reset_first", 32'(gport[0]), 32'd0);
            check("post_reset_second", 32'(gport[1]), 32'd1);
        end
        nd += 2;
        wait_done(nd);

        // Lone req_1 after reset is granted straight away.
        do_reset();
        v = mk(1, 0, 32'hE0, 0, 1, 1, 0, 32'h13579BDF, 0, 32'h13579BDF, 0, 0, 0, 0);
        c0 = cyc;
        issue(v, g);
        nd++;
        check("lone_req1_gnt_lat", 32'(g - c0), 32'd1);
        wait_done(nd);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
